// File: rtl/register_file_sb_if.sv
// register_file_sb_if: read/write/scoreboard bus between the issue stage, writeback and register_file_sb.
interface register_file_sb_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic              clear;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [XLEN-1:0]   read_data1;
    logic [XLEN-1:0]   read_data2;
    logic              busy1;
    logic              busy2;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [XLEN-1:0]   write_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_reg;
    logic              ready;

    modport master (
        output clear, read_reg1, read_reg2, reg_write, write_reg, write_data, issue_valid, issue_reg,
        input  read_data1, read_data2, busy1, busy2, ready
    );

    modport slave (
        input  clear, read_reg1, read_reg2, reg_write, write_reg, write_data, issue_valid, issue_reg,
        output read_data1, read_data2, busy1, busy2, ready
    );
endinterface

// File: rtl/register_file_sb.sv
// register_file_sb: 2R/1W register file with clear sequencer and busy scoreboard.
// Define REGFILE_BYPASS_EN for write-first forwarding on both read ports.
module register_file_sb #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input logic               clk,
    input logic               reset,
    register_file_sb_if.slave bus
);
    typedef enum logic {INIT, READY} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [XLEN-1:0]     mem_q [NUM_REGS];
    logic                ready, wr_en, iss_en, fwd1, fwd2;

    function automatic logic is_zero(input logic [ADDR_W-1:0] idx);
        return ZERO_REG != 0 && idx == '0;
    endfunction

    assign ready  = state_q == READY;
    assign wr_en  = ready && bus.reg_write && !is_zero(bus.write_reg);
    assign iss_en = ready && bus.issue_valid && !is_zero(bus.issue_reg);

    // Counter wraps to 0 on the last clear edge since NUM_REGS is a power of 2
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (state_q == INIT) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == ADDR_W'(NUM_REGS - 1) ? READY : INIT;
        end else if (bus.clear) begin
            state_d = INIT;
            cnt_d   = '0;
            busy_d  = '0;
        end else begin
            if (bus.reg_write) busy_d[bus.write_reg] = 1'b0;
            if (iss_en) busy_d[bus.issue_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Storage has no reset; the INIT sweep zeroes it instead
    always_ff @(posedge clk) begin
        if (!ready) mem_q[cnt_q] <= '0;
        else if (wr_en) mem_q[bus.write_reg] <= bus.write_data;
    end

`ifdef REGFILE_BYPASS_EN
    assign fwd1 = wr_en && bus.write_reg == bus.read_reg1;
    assign fwd2 = wr_en && bus.write_reg == bus.read_reg2;
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign bus.read_data1 = !ready || is_zero(bus.read_reg1) ? '0 : fwd1 ? bus.write_data : mem_q[bus.read_reg1];
    assign bus.read_data2 = !ready || is_zero(bus.read_reg2) ? '0 : fwd2 ? bus.write_data : mem_q[bus.read_reg2];
    assign bus.busy1      = ready && busy_q[bus.read_reg1];
    assign bus.busy2      = ready && busy_q[bus.read_reg2];
    assign bus.ready      = ready;
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: randomized bench for register_file_sb against a behavioural model, plus directed cases.
module tb_register_file_sb;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    register_file_sb_if b ();
    register_file_sb_if #(.XLEN(64), .ADDR_W(4)) c ();

    register_file_sb dut_b (.clk(clk), .reset(reset), .bus(b));
    register_file_sb #(.XLEN(64), .NUM_REGS(16), .ADDR_W(4), .ZERO_REG(0)) dut_c (.clk(clk), .reset(reset), .bus(c));

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Model of dut_b: edges of clearing still owed, register values, pending producers
    int          m_left = 32;
    logic [31:0] m_regs [32];
    logic [31:0] m_busy = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left <= 32;
            m_busy <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) for (int i = 0; i < 32; i++) m_regs[i] <= '0;
        end else if (b.clear) begin
            m_left <= 32;
            m_busy <= '0;
        end else begin
            if (b.reg_write && b.write_reg != 0) m_regs[b.write_reg] <= b.write_data;
            if (b.reg_write) m_busy[b.write_reg] <= 1'b0;
            if (b.issue_valid && b.issue_reg != 0) m_busy[b.issue_reg] <= 1'b1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] r);
        if (!(reset && m_left == 0) || r == 0) return '0;
        if (BYP && b.reg_write && b.write_reg == r) return b.write_data;
        return m_regs[r];
    endfunction

    always @(negedge clk) begin
        chk("ready", b.ready, reset && m_left == 0);
        chk("rd1", b.read_data1, exp_rd(b.read_reg1));
        chk("rd2", b.read_data2, exp_rd(b.read_reg2));
        chk("busy1", b.busy1, reset && m_left == 0 && m_busy[b.read_reg1]);
        chk("busy2", b.busy2, reset && m_left == 0 && m_busy[b.read_reg2]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int nb, output int nc);
        nb = 0;
        nc = 0;
        for (int n = 1; n <= 40 && nb == 0; n++) begin
            step();
            if (c.ready && nc == 0) nc = n;
            if (b.ready) nb = n;
        end
    endtask

    initial begin
        int nb, nc;
        b.clear = 0; b.read_reg1 = 5; b.read_reg2 = 0; b.reg_write = 0; b.write_reg = 0;
        b.write_data = 0; b.issue_valid = 0; b.issue_reg = 0;
        c.clear = 0; c.read_reg1 = 0; c.read_reg2 = 0; c.reg_write = 0; c.write_reg = 0;
        c.write_data = 0; c.issue_valid = 0; c.issue_reg = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        wait_ready(nb, nc);
        chk("init_edges", nb, 32);
        chk("init_edges_c", nc, 16);
        chk("x5_after_init", b.read_data1, 0);
        // Write x3, read back alongside x0
        b.reg_write = 1; b.write_reg = 3; b.write_data = 32'hDEADBEEF;
        step();
        b.reg_write = 0; b.read_reg1 = 3; b.read_reg2 = 0;
        @(negedge clk);
        chk("x3_read", b.read_data1, 32'hDEADBEEF);
        chk("x0_read", b.read_data2, 0);
        step();
        b.reg_write = 1; b.write_reg = 0; b.write_data = 32'h1234;
        step();
        b.reg_write = 0;
        @(negedge clk);
        chk("x0_after_write", b.read_data2, 0);
        step();
        b.reg_write = 1; b.write_reg = 7; b.write_data = 32'hA5A5A5A5; b.read_reg1 = 7;
        @(negedge clk);
        chk("x7_same_cycle", b.read_data1, BYP ? 32'hA5A5A5A5 : 32'h0);
        step();
        b.reg_write = 0;
        @(negedge clk);
        chk("x7_next_cycle", b.read_data1, 32'hA5A5A5A5);
        // Scoreboard
        step();
        b.read_reg1 = 9; b.issue_valid = 1; b.issue_reg = 9;
        step();
        b.issue_valid = 0;
        @(negedge clk);
        chk("x9_issued", b.busy1, 1);
        step();
        b.reg_write = 1; b.write_reg = 9; b.write_data = 32'h99;
        step();
        b.reg_write = 0;
        @(negedge clk);
        chk("x9_written", b.busy1, 0);
        step();
        b.reg_write = 1; b.issue_valid = 1;
        step();
        b.reg_write = 0; b.issue_valid = 0;
        @(negedge clk);
        chk("x9_set_wins", b.busy1, 1);
        step();
        b.issue_valid = 1; b.issue_reg = 0; b.read_reg2 = 0;
        step();
        b.issue_valid = 0;
        @(negedge clk);
        chk("x0_never_busy", b.busy2, 0);
        // Clear with x4 busy; write and issue held through INIT must be dropped
        step();
        b.read_reg1 = 4; b.issue_valid = 1; b.issue_reg = 4;
        step();
        b.issue_valid = 0;
        @(negedge clk);
        chk("x4_issued", b.busy1, 1);
        step();
        b.clear = 1;
        step();
        b.clear = 0; b.reg_write = 1; b.write_reg = 3; b.write_data = 32'h55; b.issue_valid = 1;
        wait_ready(nb, nc);
        b.reg_write = 0; b.issue_valid = 0; b.read_reg2 = 3;
        chk("clear_edges", nb, 32);
        @(negedge clk);
        chk("x4_busy_cleared", b.busy1, 0);
        chk("x3_cleared", b.read_data2, 0);
        // Reset pulse ten edges into a clear sequence
        step();
        b.clear = 1;
        step();
        b.clear = 0;
        repeat (9) step();
        reset = 1'b0;
        #2 reset = 1'b1;
        wait_ready(nb, nc);
        chk("reinit_edges", nb, 32);
        chk("reinit_edges_c", nc, 16);
        // 64-bit, 16-entry instance with an ordinary x0
        c.reg_write = 1; c.write_reg = 0; c.write_data = 64'hFEDCBA9876543210;
        step();
        c.reg_write = 0; c.read_reg1 = 0;
        @(negedge clk);
        chk("c_x0_roundtrip", c.read_data1, 64'hFEDCBA9876543210);
        step();
        c.reg_write = 1; c.write_reg = 15; c.write_data = 64'h0123456789ABCDEF; c.read_reg2 = 15;
        step();
        c.reg_write = 0; c.issue_valid = 1; c.issue_reg = 0;
        step();
        c.issue_valid = 0;
        @(negedge clk);
        chk("c_x15_roundtrip", c.read_data2, 64'h0123456789ABCDEF);
        chk("c_x0_busy", c.busy1, 1);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            reset = $urandom_range(0, 499) != 0;
            b.clear = $urandom_range(0, 99) == 0;
            b.reg_write = $urandom_range(0, 1) == 1;
            b.write_reg = 5'($urandom_range(0, 31));
            b.write_data = $urandom;
            b.issue_valid = $urandom_range(0, 2) == 0;
            b.issue_reg = $urandom_range(0, 3) == 0 ? b.write_reg : 5'($urandom_range(0, 31));
            b.read_reg1 = $urandom_range(0, 2) == 0 ? b.write_reg : 5'($urandom_range(0, 31));
            b.read_reg2 = $urandom_range(0, 2) == 0 ? b.issue_reg : 5'($urandom_range(0, 31));
        end
        step();
        reset = 1'b1; b.clear = 0; b.reg_write = 0; b.issue_valid = 0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
Parametrised successor to the core's integer register file, generalised in data width and depth.
- Two combinational read ports and one synchronous write port.
- Post-reset clear sequencer, so the storage array needs no reset.
- Per-register busy scoreboard for in-flight producers, used by the issue stage.
- Sits between decode/issue and writeback in the RISC-V core.

Parameters:
XLEN, 32, data width of each register in bits
NUM_REGS, 32, number of architectural registers; must be a power of 2 and at least 2
ADDR_W, 5, register index width; must equal log2(NUM_REGS)
ZERO_REG, 1, when 1 register 0 is hardwired to zero and never busy; when 0 it is an ordinary register

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous request to re-run the clear sequence; sampled only when ready=1
read_reg1  input  ADDR_W  read port 1 index
read_reg2  input  ADDR_W  read port 2 index
read_data1  output  XLEN  read port 1 data
read_data2  output  XLEN  read port 2 data
busy1  output  1  scoreboard bit for read_reg1
busy2  output  1  scoreboard bit for read_reg2
reg_write  input  1  write enable; also releases the scoreboard entry
write_reg  input  ADDR_W  write index
write_data  input  XLEN  write data
issue_valid  input  1  marks issue_reg as having a pending producer
issue_reg  input  ADDR_W  destination index of the issued instruction
ready  output  1  high once the register file is initialised and accepting traffic

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM enters INIT; clear counter = 0; ready = 0; all busy bits = 0.
  - The storage array is not reset.
- FSM states:
  - INIT:
    - Each rising edge writes 0 to reg[counter] and increments counter.
    - On the edge that clears reg[NUM_REGS-1], go to READY and set ready = 1.
    - ready is therefore first high after NUM_REGS rising edges following reset release.
  - READY:
    - clear=1 on a rising edge: go to INIT, ready = 0, counter = 0, all busy bits = 0.
- While ready=0:
  - read_data1/2 = 0 and busy1/2 = 0.
  - reg_write, issue_valid and clear are ignored. Writes are dropped, not queued.
- Reads are combinational:
  - read_dataN = reg[read_regN], subject to the optional bypass below.
  - busyN = busy[read_regN].
- Write:
  - On a rising edge with ready=1 and reg_write=1, reg[write_reg] <= write_data.
  - With ZERO_REG=1, writes to index 0 are discarded and reads of index 0 return 0.
- Scoreboard (same edge, ready=1):
  - reg_write=1 clears busy[write_reg].
  - issue_valid=1 sets busy[issue_reg].
  - When issue_reg == write_reg and both are valid, set wins and the entry stays busy (a new producer supersedes the completing one).
  - With ZERO_REG=1, busy[0] is never set.
  - Issuing to an already-busy register leaves it busy; there is no error.
- Reset asserted mid-operation:
  - Immediate return to INIT; busy = 0; ready = 0.
  - Array contents are undefined until the clear sequence completes.
- All index comparisons are full ADDR_W width; no wrap-around beyond NUM_REGS.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-first forwarding on both read ports. If ready=1, reg_write=1, write_reg == read_regN, and (ZERO_REG=0 or write_reg != 0), then read_dataN = write_data in the same cycle.
- Undefined: no forwarding. read_dataN returns the pre-write value until the edge after the write.
- Scoreboard behaviour is identical in both builds.

Test Plan:
- Reset release with defaults: ready stays 0 for 32 edges and rises after the 32nd. Reading x5 before and after gives 0 throughout.
- ready=1; write x3=0xDEADBEEF; next cycle read_reg1=3, read_reg2=0 -> read_data1=0xDEADBEEF, read_data2=0. Then write x0=0x1234 -> read of x0 stays 0.
- Same-cycle write x7=0xA5A5A5A5 with read_reg1=7:
  - Bypass build: read_data1=0xA5A5A5A5 that cycle.
  - Non-bypass build: old value (0) that cycle, then 0xA5A5A5A5 the next cycle.
- Scoreboard sequence:
  - issue x9 -> busy1=1 (read_reg1=9).
  - Write x9 -> busy1=0.
  - issue x9 and write x9 on the same edge -> busy1 stays 1.
  - issue x0 -> busy stays 0.
- Issue x4, then assert clear: ready=0 for 32 edges; busy for x4 = 0; x3 reads 0 after ready returns. A write attempted during INIT is dropped.
- Mid-INIT reset pulse (reset low after 10 edges): counter restarts and ready rises exactly 32 edges after release. Repeat with XLEN=64, NUM_REGS=16, ADDR_W=4 -> ready after 16 edges and a 64-bit write/read round-trips.
